// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - seconds countdown timer with prescaler, hold/pause and expiry pulse
// Optional registered BCD digit outputs are built only when WAIT_TIMER_BCD_EN is defined.
module wait_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       hold,
    input  logic [4:0] wtime,
    output logic [4:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       expired,
    output logic [3:0] digit_ones,
    output logic [3:0] digit_tens
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    // 26 bits covers the largest legal divider (2^26 - 1 terminal count).
    localparam int            PW        = 26;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4:0]      rem_q, rem_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = S_IDLE;
            presc_d = '0;
            rem_d   = '0;
        end else if (start) begin
            presc_d = '0;
            rem_d   = wtime;
            if (wtime != 5'd0) begin
                state_d = S_RUN;
            end else begin
                state_d = S_EXPIRED;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hold) begin
                        state_d = S_PAUSE;
                    end else if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        if (rem_q > 5'd1) begin
                            rem_d = rem_q - 5'd1;
                        end else begin
                            rem_d   = '0;
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                // Resuming only changes state; the frozen prescaler restarts counting next cycle.
                S_PAUSE: begin
                    if (!hold) begin
                        state_d = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    rem_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        remaining = rem_q;
        busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
        expired   = (state_q == S_EXPIRED);
        done      = done_q;
    end

`ifdef WAIT_TIMER_BCD_EN
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    // Digits are derived from the next remaining value so they change with it.
    always_comb begin
        ones_d = 4'(rem_d % 5'd10);
        tens_d = 4'(rem_d / 5'd10);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    always_comb begin
        digit_ones = ones_q;
        digit_tens = tens_q;
    end
`else
    always_comb begin
        digit_ones = 4'd0;
        digit_tens = 4'd0;
    end
`endif

endmodule

// File: tb/tb_wait_timer.sv
// tb/tb_wait_timer.sv - self-checking bench for wait_timer against an elapsed-time reference model
module tb_wait_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cancel;
    logic       hold;
    logic [4:0] wtime;
    logic [4:0] remaining;
    logic       busy;
    logic       done;
    logic       expired;
    logic [3:0] digit_ones;
    logic [3:0] digit_tens;

    wait_timer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cancel     (cancel),
        .hold       (hold),
        .wtime      (wtime),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .expired    (expired),
        .digit_ones (digit_ones),
        .digit_tens (digit_tens)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int busy_seen = 0;

    // Reference: a loaded time plus a count of un-held running cycles since the load.
    bit m_active, m_paused, m_exp, m_done;
    int m_load, m_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_rem();
        return m_active ? (m_load - m_n / TD) : 0;
    endfunction

    function automatic void model_reset();
        m_active = 0; m_paused = 0; m_exp = 0; m_done = 0;
        m_load = 0; m_n = 0;
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (cancel) begin
            m_active = 0; m_paused = 0; m_exp = 0; m_load = 0; m_n = 0;
        end else if (start) begin
            m_load = int'(wtime); m_n = 0; m_paused = 0;
            m_active = (wtime != 0);
            m_exp    = (wtime == 0);
            m_done   = (wtime == 0);
        end else if (m_active) begin
            if (m_paused) begin
                m_paused = hold;
            end else if (hold) begin
                m_paused = 1;
            end else begin
                m_n++;
                if (m_n == m_load * TD) begin
                    m_active = 0; m_exp = 1; m_done = 1;
                end
            end
        end
    endfunction

    task automatic check_all();
        int r;
        r = m_rem();
        check("remaining", 32'(remaining), 32'(r));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("expired", 32'(expired), 32'(m_exp));
`ifdef WAIT_TIMER_BCD_EN
        check("digit_tens", 32'(digit_tens), 32'(r / 10));
        check("digit_ones", 32'(digit_ones), 32'(r % 10));
`else
        check("digit_tens", 32'(digit_tens), 32'd0);
        check("digit_ones", 32'(digit_ones), 32'd0);
`endif
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1) busy_seen++;
    endtask

    task automatic drive(input logic s, input logic c, input logic h, input logic [4:0] w);
        start = s; cancel = c; hold = h; wtime = w;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 5'd0);
        model_reset();
        #2 reset = 1'b0;
        #1 check_all();
        run(3);
        reset = 1'b1;
        run(5);

        // Normal countdown from 3; later wtime changes must be ignored.
        drive(1, 0, 0, 5'd3);
        tick_cycle();
        check("busy_after_start", 32'(busy), 32'd1);
        drive(0, 0, 0, 5'd17);
        done_seen = 0;
        run(16);
        check("done_pulses_3", 32'(done_seen), 32'd1);
        check("expired_level", 32'(expired), 32'd1);

        // Zero load expires at once without ever going busy.
        busy_seen = 0; done_seen = 0;
        drive(1, 0, 0, 5'd0);
        tick_cycle();
        check("zero_done", 32'(done), 32'd1);
        drive(0, 0, 0, 5'd0);
        run(5);
        check("zero_busy_never", 32'(busy_seen), 32'd0);
        check("zero_done_pulses", 32'(done_seen), 32'd1);

        // Hold for 10 cycles after 2 running cycles.
        drive(1, 0, 0, 5'd2);
        tick_cycle();
        drive(0, 0, 0, 5'd2);
        run(2);
        hold = 1'b1;
        run(10);
        check("hold_frozen", 32'(remaining), 32'd2);
        hold = 1'b0;
        run(14);

        // start+cancel together: cancel wins.
        drive(1, 0, 0, 5'd7);
        tick_cycle();
        drive(0, 0, 0, 5'd7);
        run(3);
        drive(1, 1, 0, 5'd9);
        tick_cycle();
        check("cancel_wins_rem", 32'(remaining), 32'd0);
        check("cancel_wins_done", 32'(done), 32'd0);
        drive(0, 0, 0, 5'd0);
        run(2);

        // Restart at remaining=5 with 31.
        drive(1, 0, 0, 5'd8);
        tick_cycle();
        drive(0, 0, 0, 5'd8);
        for (int i = 0; i < 40 && m_rem() != 5; i++) tick_cycle();
        check("reached_5", 32'(remaining), 32'd5);
        drive(1, 0, 0, 5'd31);
        tick_cycle();
        check("restart_31", 32'(remaining), 32'd31);
        check("restart_no_done", 32'(done), 32'd0);
        drive(0, 0, 0, 5'd0);
        run(6);

        // BCD load of 27 then one tick.
        drive(1, 0, 0, 5'd27);
        tick_cycle();
        drive(0, 0, 0, 5'd0);
        run(4);

        // Asynchronous reset mid-count.
        drive(1, 0, 0, 5'd9);
        tick_cycle();
        drive(0, 0, 0, 5'd0);
        run(2);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        check("reset_rem_now", 32'(remaining), 32'd0);
        run(2);
        reset = 1'b1;
        run(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0 ? 1'b1 : (hold & ($urandom_range(0, 3) != 0)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4)));
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                model_reset();
                #1 check_all();
                tick_cycle();
                reset = 1'b1;
            end
            tick_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
